sobel_frame_ctrl: RTL and testbench

Frame-level sequencer wrapped around sobel_filter. Accepts a frame of 128-bit pixel words from an upstream ready/valid stream and feeds the filter, which has no backpressure. Issue is throttled with credits so every filter result fits in a local output FIFO. The block drains the results to a downstream ready/valid stream tagged with end-of-line and end-of-frame markers, and reports busy, done and error status.

---
 rtl/sobel_frame_ctrl.sv | 155 +++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer around sobel_filter: credit-throttled issue, FWFT result FIFO,
// and a ready/valid output stream tagged with end-of-line and end-of-frame.
module sobel_frame_ctrl #(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned DIM_W      = 12,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] f_data_in,
    output logic              f_valid_in,
    input  logic [DATA_W-1:0] f_data_out,
    input  logic              f_valid_out,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_eol,
    output logic              m_last
);

    localparam int unsigned CW = 2 * DIM_W;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = PW + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [DIM_W-1:0]  width_q, width_d, col_q, col_d;
    logic [CW-1:0]     total_q, total_d, issued_q, issued_d, emitted_q, emitted_d;
    logic [CW-1:0]     cfg_total;
    logic [NW-1:0]     inflight_q, inflight_d, count_q, count_d;
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DATA_W-1:0] f_data_q, f_data_d;
    logic              f_valid_q, err_q, err_d;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic start_acc, full, credit_ok, hs, rd, orphan, overflow, wr, ret;

    assign cfg_total = CW'(cfg_width) * CW'(cfg_height);
    assign start_acc = start && (state_q == StIdle);
    assign full      = (count_q == NW'(FIFO_DEPTH));
    assign credit_ok = ({1'b0, inflight_q} + {1'b0, count_q}) < (NW + 1)'(FIFO_DEPTH);
    assign s_ready   = (state_q == StRun) && (issued_q < total_q) && credit_ok;
    assign hs        = s_valid && s_ready;
    assign m_valid   = (count_q != '0);
    assign rd        = m_valid && m_ready;
    // A result with no outstanding credit, or one arriving into a full FIFO, is dropped.
    assign orphan    = f_valid_out && (inflight_q == '0);
    assign overflow  = f_valid_out && !orphan && full && !rd;
    assign ret       = f_valid_out && !orphan;
    assign wr        = ret && !overflow;

    assign m_data     = m_valid ? mem[rptr_q] : '0;
    assign m_eol      = m_valid && (col_q == width_q - DIM_W'(1));
    assign m_last     = m_valid && (emitted_q == total_q - CW'(1));
    assign busy       = (state_q == StRun) || (state_q == StDrain);
    assign done       = (state_q == StDone);
    assign err        = err_q;
    assign f_data_in  = f_data_q;
    assign f_valid_in = f_valid_q;

    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        total_d    = total_q;
        issued_d   = issued_q + CW'(hs);
        emitted_d  = emitted_q + CW'(rd);
        col_d      = col_q;
        inflight_d = inflight_q;
        count_d    = count_q;
        wptr_d     = wptr_q + PW'(wr);
        rptr_d     = rptr_q + PW'(rd);
        f_data_d   = hs ? s_data : f_data_q;
        err_d      = err_q;

        if (rd) col_d = m_eol ? '0 : col_q + DIM_W'(1);

        unique case ({hs, ret})
            2'b10:   inflight_d = inflight_q + NW'(1);
            2'b01:   inflight_d = inflight_q - NW'(1);
            default: inflight_d = inflight_q;
        endcase

        unique case ({wr, rd})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase

        if (start_acc) begin
            width_d   = cfg_width;
            total_d   = cfg_total;
            issued_d  = '0;
            emitted_d = '0;
            col_d     = '0;
            err_d     = 1'b0;
        end
        if (orphan || overflow) err_d = 1'b1;

        unique case (state_q)
            StIdle:  if (start) state_d = (cfg_total == '0) ? StDone : StRun;
            StRun:   if (issued_q == total_q) state_d = StDrain;
            // Leave on the final read so done lands the cycle after the m_last handshake.
            StDrain: if (emitted_d == total_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            width_q    <= '0;
            total_q    <= '0;
            issued_q   <= '0;
            emitted_q  <= '0;
            col_q      <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            f_data_q   <= '0;
            f_valid_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            total_q    <= total_d;
            issued_q   <= issued_d;
            emitted_q  <= emitted_d;
            col_q      <= col_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            f_data_q   <= f_data_d;
            f_valid_q  <= hs;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr_q] <= f_data_out;
    end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl with a 3-cycle inverting filter model.
module tb_sobel_frame_ctrl;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned DIM_W  = 12;
    localparam int unsigned DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [DIM_W-1:0]  cfg_width = '0, cfg_height = '0;
    logic              busy, done, err;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_valid = 1'b0, s_ready;
    logic [DATA_W-1:0] f_data_in, f_data_out;
    logic              f_valid_in, f_valid_out;
    logic [DATA_W-1:0] m_data;
    logic              m_valid, m_eol, m_last;
    logic              m_ready = 1'b0;
    logic              inj = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sobel_frame_ctrl #(.DATA_W(DATA_W), .DIM_W(DIM_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .busy(busy), .done(done), .err(err),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .f_data_in(f_data_in), .f_valid_in(f_valid_in),
        .f_data_out(f_data_out), .f_valid_out(f_valid_out),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_eol(m_eol), .m_last(m_last)
    );

    // Filter model: fixed latency 3, result is the bitwise inverse of the input word.
    logic [2:0]        pv;
    logic [DATA_W-1:0] pd [3];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv <= '0;
        end else begin
            pv    <= {pv[1:0], f_valid_in};
            pd[0] <= f_data_in;
            pd[1] <= pd[0];
            pd[2] <= pd[1];
        end
    end
    assign f_valid_out = pv[2] | inj;
    assign f_data_out  = ~pd[2];

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] word(input int i);
        return {32'h5EB0_0000 ^ 32'(i * 7), 32'(i), ~32'(i), 32'hC0DE_0000 + 32'(i)};
    endfunction

    task automatic run_frame(input int w, input int h, input int s_pct, input int m_pct,
                             input int hold);
        int total, sent, got, cyc, max_out, first_done, done_cnt;
        bit prev_hs, prev_last, bad_tag, bad_fvi, sr_seen, mv_seen;
        logic [DATA_W-1:0] prev_word;
        total = w * h;
        sent = 0; got = 0; cyc = 0; max_out = 0; first_done = -1; done_cnt = 0;
        prev_hs = 0; prev_last = 0; bad_tag = 0; bad_fvi = 0; sr_seen = 0; mv_seen = 0;
        prev_word = '0;
        @(negedge clk);
        cfg_width = DIM_W'(w); cfg_height = DIM_W'(h);
        start = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        while (cyc < 3000 && !(first_done >= 0 && cyc >= first_done + 3)) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc == 1) check("err_cleared_on_start", err, 0);
            if (f_valid_in !== prev_hs || (prev_hs && f_data_in !== prev_word)) bad_fvi = 1;
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = cyc;
            end
            if (prev_last) check("done_after_last", done, 1);
            prev_last = 0;
            if (s_ready) sr_seen = 1;
            if (m_valid) mv_seen = 1;
            if (!m_valid && (m_eol || m_last)) bad_tag = 1;
            if (hold > 0 && cyc == hold) begin
                check("stall_issued", sent, (total < DEPTH) ? total : DEPTH);
                check("stall_s_ready", s_ready, 0);
                check("stall_err", err, 0);
            end
            m_ready = (cyc > hold) && ($urandom_range(99) < m_pct);
            if (m_valid && m_ready) begin
                check("data", m_data, ~word(got));
                check("eol", m_eol, ((got % w) == w - 1));
                check("last", m_last, (got == total - 1));
                if (got == total - 1) prev_last = 1;
                got++;
            end
            s_valid = ($urandom_range(99) < s_pct);
            s_data  = word(sent);
            prev_hs = s_valid && s_ready;
            prev_word = s_data;
            if (prev_hs) sent++;
            if (sent - got > max_out) max_out = sent - got;
        end
        s_valid = 1'b0; m_ready = 1'b0;
        check("words_out", got, total);
        check("done_pulses", done_cnt, 1);
        check("credit_bound", (max_out <= DEPTH), 1);
        check("tags_idle_zero", bad_tag, 0);
        check("issue_reg", bad_fvi, 0);
        check("frame_err", err, 0);
        check("busy_after", busy, 0);
        if (total == 0) begin
            check("zero_done_latency", (first_done >= 1 && first_done <= 2), 1);
            check("zero_no_s_ready", sr_seen, 0);
            check("zero_no_m_valid", mv_seen, 0);
        end
    endtask

    initial begin
        int got;
        bit saw_done;
        #3;
        check("rst_ctrl", {busy, done, err, s_ready, f_valid_in, m_valid, m_eol, m_last}, 0);
        check("rst_m_data", m_data, 0);
        @(negedge clk);
        rst = 1'b1;

        run_frame(4, 2, 100, 100, 0);
        run_frame(4, 4, 100, 100, 40);
        run_frame(0, 5, 100, 100, 0);
        run_frame(3, 5, 50, 50, 0);

        // Abort an 8-word frame after its fifth output word.
        @(negedge clk);
        cfg_width = 4; cfg_height = 2; start = 1'b1;
        @(negedge clk);
        start = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 200 && got < 5; i++) begin
            @(negedge clk);
            if (m_valid && m_ready) got++;
        end
        check("abort_reached_word5", got, 5);
        #2 rst = 1'b0;
        #1;
        check("abort_ctrl", {busy, done, err, s_ready, f_valid_in, m_valid, m_eol, m_last}, 0);
        check("abort_f_data", f_data_in, 0);
        check("abort_m_data", m_data, 0);
        s_valid = 1'b0; m_ready = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check("abort_no_done", saw_done, 0);
        run_frame(2, 1, 100, 100, 0);

        // Stray filter result while idle.
        @(negedge clk);
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        check("stray_err", err, 1);
        check("stray_no_m_valid", m_valid, 0);
        @(negedge clk);
        check("stray_err_sticky", err, 1);
        check("stray_still_empty", m_valid, 0);
        run_frame(2, 2, 100, 100, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
